// File: rtl/ssd_seq_pkg.sv
// Shared types and constants for the SSD state-code sequencer.
// Code 0 means idle; event index i is shown as code i+1.
package ssd_seq_pkg;

    localparam int STATE_W = 4;
    localparam int NUM_EVT = 9;
    localparam logic [STATE_W-1:0] ST_IDLE = 4'd0;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } fsm_t;

    function automatic logic [STATE_W-1:0] code_of(input logic [STATE_W-1:0] idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/ssd_state_seq_if.sv
// Bundle between the core-side event source and the sequencer.
// The sequencer uses the slave view; the event source uses the master view.
interface ssd_state_seq_if;
    import ssd_seq_pkg::*;

    logic [NUM_EVT-1:0] evt;
    logic               clr;
    logic [STATE_W-1:0] state;
    logic               busy;
    logic [NUM_EVT-1:0] pending;
    logic               overrun;

    modport master (
        output evt,
        output clr,
        input  state,
        input  busy,
        input  pending,
        input  overrun
    );

    modport slave (
        input  evt,
        input  clr,
        output state,
        output busy,
        output pending,
        output overrun
    );

endinterface

// File: rtl/prio_enc9.sv
// Highest-set-bit encoder for a 9-bit request vector.
// idx is only meaningful while valid is high.
module prio_enc9
    import ssd_seq_pkg::*;
(
    input  logic [NUM_EVT-1:0] vec,
    output logic               valid,
    output logic [STATE_W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (vec[i]) begin
                idx = STATE_W'(i);
            end
        end
        valid = |vec;
    end

endmodule

// File: rtl/ssd_state_seq.sv
// Queues edge-detected event requests and shows each as a state code for
// at least HOLD_US cycles, with optional preemption by masked events.
module ssd_state_seq
    import ssd_seq_pkg::*;
#(
    parameter int                 HOLD_US      = 1000000,
    parameter logic [NUM_EVT-1:0] PREEMPT_MASK = 9'b100000000,
    parameter int                 CNT_W        = 20
) (
    input  logic          clkus,
    input  logic          rst_n,
    ssd_state_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_US - 1);

    logic [NUM_EVT-1:0] evt_q;
    logic [NUM_EVT-1:0] rise;
    logic [NUM_EVT-1:0] take;
    fsm_t               fsm;
    logic [CNT_W-1:0]   cnt;

    logic               win_vld;
    logic [STATE_W-1:0] win_idx;
    logic               pre_vld;
    logic [STATE_W-1:0] pre_idx;
    logic               load;
    logic [STATE_W-1:0] load_idx;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    prio_enc9 u_win (
        .vec   (bus.pending),
        .valid (win_vld),
        .idx   (win_idx)
    );

    prio_enc9 u_pre (
        .vec   (bus.pending & PREEMPT_MASK),
        .valid (pre_vld),
        .idx   (pre_idx)
    );

    assign rise = bus.evt & ~evt_q;

    always_comb begin
        load     = 1'b0;
        load_idx = win_idx;
        unique case (fsm)
            IDLE: load = win_vld;
            SHOW: begin
                if (cnt == '0) begin
                    load = win_vld;
                end else if (pre_vld && (code_of(pre_idx) > bus.state)) begin
                    load     = 1'b1;
                    load_idx = pre_idx;
                end
            end
            default: load = 1'b0;
        endcase
        take = load ? (NUM_EVT'(1) << load_idx) : '0;
    end

    // A fresh edge on the bit being consumed re-queues it without an overrun.
    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            evt_q       <= '0;
            bus.pending <= '0;
            bus.overrun <= 1'b0;
        end else begin
            evt_q <= bus.evt;
            if (bus.clr) begin
                bus.pending <= '0;
                bus.overrun <= 1'b0;
            end else begin
                bus.pending <= (bus.pending & ~take) | rise;
                bus.overrun <= |(rise & bus.pending & ~take);
            end
        end
    end

    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            bus.state <= ST_IDLE;
            bus.busy  <= 1'b0;
            cnt       <= '0;
        end else if (bus.clr) begin
            fsm       <= IDLE;
            bus.state <= ST_IDLE;
            bus.busy  <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            fsm       <= SHOW;
            bus.state <= code_of(load_idx);
            bus.busy  <= 1'b1;
            cnt       <= HOLD_LOAD;
        end else begin
            unique case (fsm)
                IDLE: begin
                    bus.state <= ST_IDLE;
                    bus.busy  <= 1'b0;
                end
                SHOW: begin
                    if (cnt == '0) begin
                        fsm       <= IDLE;
                        bus.state <= ST_IDLE;
                        bus.busy  <= 1'b0;
                    end else begin
                        cnt <= dec_sat(cnt);
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ssd_state_seq.md
Name: ssd_state_seq

Overview:
Upstream feeder for the SSD display stage. Collects one-cycle or level event requests from the core logic and queues them as pending codes. Drives the 4-bit state code consumed by the SSD block, holding each code for a guaranteed minimum display time. Returns to the idle code (0) when nothing is pending. The output never exceeds 9, so the SSD block never falls into its out-of-range handling.

Parameters:
HOLD_US, 1000000, minimum display time per code, in clkus cycles (1 s); must be ≥2
PREEMPT_MASK, 9'b100000000, per-event mask; a masked pending event may cut short the hold of a lower code
CNT_W, 20, hold counter width; must satisfy 2^CNT_W > HOLD_US-1

Ports:
clkus  in  1  1 MHz system tick clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
evt  in  9  event requests; evt[i] maps to state code i+1; edge-detected
clr  in  1  synchronous flush: drop all pending events and return to idle
state  out  4  code to the SSD stage: 0 = idle, 1..9 = event code
busy  out  1  1 while a nonzero code is being shown
pending  out  9  queued, not yet shown events
overrun  out  1  one-cycle pulse when an event edge hits an already-pending bit

Behaviour:
- Reset (async, rst_n=0): state=0, busy=0, pending=0, overrun=0, evt_q=0, hold counter=0, FSM=IDLE. Because evt_q resets to 0, an evt bit held high through reset release registers as an edge on the first clkus edge.
- Edge detect: evt_q <= evt every cycle. A rising edge on bit i is evt[i]&~evt_q[i]. A level held high generates exactly one request.
- Pending set: a rising edge on bit i sets pending[i] at that clock edge. If pending[i] was already 1, overrun=1 for that one cycle and pending stays 1.
- Priority: the highest index pending bit wins (code 9 is highest).
- FSM IDLE: state=0, busy=0.
  - At any edge where pending≠0: state <= winner+1, clear that pending bit, load cnt=HOLD_US-1, go to SHOW.
  - Latency: edge sampled at clock S, pending set after S, state valid after S+1.
- FSM SHOW: busy=1, cnt decrements by 1 per cycle.
  - When cnt==0 and pending≠0: load the next winner as in IDLE. There is no idle gap between codes.
  - When cnt==0 and pending==0: state<=0, go to IDLE.
  - Result: each code is displayed for exactly HOLD_US cycles unless preempted.
- Preemption (SHOW, cnt≠0): if the winner among (pending & PREEMPT_MASK) has code > current state, switch to it immediately. Clear its pending bit and reload cnt. The displaced code is discarded, not requeued.
- Simultaneous set and clear on the same bit at the same edge (new edge while that bit is being consumed): set wins, pending[i]=1. The re-arrival is shown later and is not counted as overrun.
- An edge on the code currently shown: it is queued normally and redisplayed after the hold.
- clr=1: highest priority. pending<=0, state<=0, busy<=0, cnt<=0, FSM=IDLE. Edges in the same cycle are discarded, with no overrun pulse. evt_q still updates.
- Reset asserted mid-hold: immediate return to the reset values. No state is retained.
- Widths: state is 4 bits and is always ≤9. cnt is CNT_W bits and saturates at 0, never wrapping.

Decomposition:
- Package ssd_seq_pkg holds:
  - ST_IDLE=4'd0
  - NUM_EVT=9
  - STATE_W=4
  - enum IDLE/SHOW
  - function code_of(idx)=idx+1
- Sub-module prio_enc9: combinational highest-set-bit encoder of a 9-bit vector. Outputs are valid flag and 4-bit index. It is instantiated twice: once on pending, once on pending&PREEMPT_MASK.

Test Plan (HOLD_US=8, PREEMPT_MASK=9'h100):
- Reset release with evt=0 → state=0, busy=0, pending=0. Then pulse evt[2] for 1 cycle at S → pending=9'h004 after S, state=3 after S+1, held for 8 cycles, then state=0, busy=0.
- evt[0] and evt[4] pulsed in the same cycle → state=5 for 8 cycles, then state=1 for 8 cycles with no idle cycle between, then state=0.
- While state=2 with cnt=5, pulse evt[8] → state=9 on the next edge, full 8-cycle hold, then state=0. Code 2 is not redisplayed.
- Pulse evt[3] twice while pending[3] is already 1 → overrun high for exactly 1 cycle on the second edge, code 4 shown only once.
- evt[1] held high for 40 cycles → exactly one display of code 2. clr asserted while state=2 with pending=9'h011 → next cycle state=0, pending=0, busy=0.
- rst_n pulled low mid-hold (state=7) → state=0 asynchronously. evt[6] held high through release → code 7 shown starting 2 edges after release.
